fsm_unit: RTL and testbench

- Colour-driven controller: debounces a one-hot 3-bit colour code, applies a command to a saturating 4-bit level, and drives a timed buzzer.
- Sits between the colour-sensor decoder (`color`) and the display/buzzer outputs.
- The level decays while the block is idle.

---
 rtl/fsm_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fsm_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_unit.sv
`default_nettype none
// ============================================================================
// Module      : fsm_unit
// Description : Colour-driven controller. It debounces a one-hot 3-bit colour
//               code and applies the accepted command to a saturating 4-bit
//               level:
//                 FEED  (001) adds STEP, saturating at MAX_LEVEL
//                 CALL  (010) leaves the level unchanged
//                 CLEAR (100) sets the level to 0
//               Every accepted command starts a timed buzzer pulse and a
//               cooldown window, during which the colour input is ignored.
//               While idle with no colour present, the level decays by one
//               unit every DECAY_CYCLES cycles.
//
// Ports       : clk     in   system clock; all state changes on the rising edge
//               reset   in   asynchronous, active-low reset
//               color   in   [2:0] colour code; any code that is not one-hot
//                            counts as "no colour"
//               data    out  [3:0] current level, 0..MAX_LEVEL
//               buzzer  out  high while the buzzer timer runs
//
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_unit #(
    parameter int DEB_CYCLES      = 2,   // consecutive samples before acceptance (>= 1)
    parameter int MAX_LEVEL       = 4,   // saturation ceiling (<= 15)
    parameter int STEP            = 2,   // FEED increment
    parameter int DECAY_CYCLES    = 10,  // idle cycles per 1-unit decrement (>= 1)
    parameter int BUZZ_CYCLES     = 50,  // buzzer high time per command (>= 1)
    parameter int COOLDOWN_CYCLES = 50   // cycles of ignored input after a command (>= 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] color,
    output logic [3:0] data,
    output logic       buzzer
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_code_feed  = 3'b001;
    localparam logic [2:0] c_code_call  = 3'b010;
    localparam logic [2:0] c_code_clear = 3'b100;

    // Every counter is sized so that it can hold its own terminal count.
    localparam int c_deb_w   = $clog2(DEB_CYCLES + 1);
    localparam int c_decay_w = $clog2(DECAY_CYCLES + 1);
    localparam int c_buzz_w  = $clog2(BUZZ_CYCLES + 1);
    localparam int c_cool_w  = $clog2(COOLDOWN_CYCLES + 1);

    // A counter is compared against its terminal value minus one, so the
    // decision is made in the same cycle as the final increment.
    localparam logic [c_deb_w-1:0]   c_deb_one    = c_deb_w'(1);
    localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_decay_w-1:0] c_decay_one  = c_decay_w'(1);
    localparam logic [c_decay_w-1:0] c_decay_last = c_decay_w'(DECAY_CYCLES - 1);
    localparam logic [c_buzz_w-1:0]  c_buzz_one   = c_buzz_w'(1);
    localparam logic [c_buzz_w-1:0]  c_buzz_load  = c_buzz_w'(BUZZ_CYCLES);
    localparam logic [c_cool_w-1:0]  c_cool_one   = c_cool_w'(1);
    localparam logic [c_cool_w-1:0]  c_cool_last  = c_cool_w'(COOLDOWN_CYCLES - 1);

    localparam logic [3:0]  c_level_max  = 4'(MAX_LEVEL);
    localparam logic [3:0]  c_level_one  = 4'd1;
    localparam logic [31:0] c_step_wide  = 32'(STEP);
    localparam logic [31:0] c_max_wide   = 32'(MAX_LEVEL);

    // State encoding
    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_check    = 2'd1;
    localparam logic [1:0] c_action   = 2'd2;
    localparam logic [1:0] c_cooldown = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [2:0]           r_cand;       // colour being debounced / applied
    logic [c_deb_w-1:0]   r_deb_cnt;    // consecutive matching samples
    logic [c_decay_w-1:0] r_decay_cnt;  // consecutive colourless IDLE cycles
    logic [c_cool_w-1:0]  r_cool_cnt;   // cycles spent in COOLDOWN
    logic [3:0]           r_level;
    logic [c_buzz_w-1:0]  r_buzz_cnt;   // remaining buzzer cycles
    logic                 r_buzz;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_valid;
    logic [31:0] w_feed_sum;
    logic [3:0]  w_feed_level;
    logic        w_fire;

    // Only an exactly one-hot code is a colour; 000 and multi-hot are not.
    assign w_valid = (color == c_code_feed) ||
                     (color == c_code_call) ||
                     (color == c_code_clear);

    // The sum is formed 32 bits wide so it can never wrap before the clamp.
    assign w_feed_sum   = 32'(r_level) + c_step_wide;
    assign w_feed_level = (w_feed_sum > c_max_wide) ? c_level_max : w_feed_sum[3:0];

    // The command takes effect on the edge that leaves ACTION.
    assign w_fire = (r_state == c_action);

    // ------------------------------------------------------------------------
    // Control state machine, level register and decay counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_idle;
            r_cand      <= '0;
            r_deb_cnt   <= '0;
            r_decay_cnt <= '0;
            r_cool_cnt  <= '0;
            r_level     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_valid) begin
                        // Latch the candidate; the first sample already counts.
                        r_cand      <= color;
                        r_deb_cnt   <= c_deb_one;
                        r_decay_cnt <= '0;
                        r_state     <= (DEB_CYCLES == 1) ? c_action : c_check;
                    end else if (r_decay_cnt == c_decay_last) begin
                        r_decay_cnt <= '0;
                        if (r_level != '0) begin
                            r_level <= r_level - c_level_one;
                        end
                    end else begin
                        r_decay_cnt <= r_decay_cnt + c_decay_one;
                    end
                end

                c_check: begin
                    r_decay_cnt <= '0;
                    if (color == r_cand) begin
                        if (r_deb_cnt == c_deb_last) begin
                            r_deb_cnt <= '0;
                            r_state   <= c_action;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + c_deb_one;
                        end
                    end else begin
                        // Any different sample, even another valid colour,
                        // drops the candidate without effect.
                        r_cand    <= '0;
                        r_deb_cnt <= '0;
                        r_state   <= c_idle;
                    end
                end

                c_action: begin
                    r_decay_cnt <= '0;
                    r_deb_cnt   <= '0;
                    r_cool_cnt  <= '0;
                    r_state     <= c_cooldown;
                    case (r_cand)
                        c_code_feed:  r_level <= w_feed_level;
                        c_code_clear: r_level <= '0;
                        default:      r_level <= r_level;  // CALL: no change
                    endcase
                end

                c_cooldown: begin
                    // Colour is ignored here; a colour still held after the
                    // window is simply debounced again from IDLE.
                    r_decay_cnt <= '0;
                    if (r_cool_cnt == c_cool_last) begin
                        r_cool_cnt <= '0;
                        r_cand     <= '0;
                        r_state    <= c_idle;
                    end else begin
                        r_cool_cnt <= r_cool_cnt + c_cool_one;
                    end
                end

                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Buzzer timer
    // Runs independently of the state machine once loaded. A new command
    // while it is running restarts the full pulse. The output flop drops on
    // the same edge the count reaches zero, so it stays high for exactly
    // BUZZ_CYCLES cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buzz_cnt <= '0;
            r_buzz     <= 1'b0;
        end else if (w_fire) begin
            r_buzz_cnt <= c_buzz_load;
            r_buzz     <= 1'b1;
        end else if (r_buzz_cnt != '0) begin
            r_buzz_cnt <= r_buzz_cnt - c_buzz_one;
            r_buzz     <= (r_buzz_cnt != c_buzz_one);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign data   = r_level;
    assign buzzer = r_buzz;

endmodule
`default_nettype wire

// File: tb/tb_fsm_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_unit
// Description : Self-checking bench for fsm_unit. Directed scenarios followed
//               by randomized colour bursts, every cycle compared against a
//               reference model that tracks run lengths and remaining times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_unit;

    localparam int DEB   = 2;
    localparam int MAXL  = 4;
    localparam int STEP  = 2;
    localparam int DECAY = 10;
    localparam int BUZZ  = 50;
    localparam int COOL  = 50;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] color = 3'b000;
    logic [3:0] data;
    logic       buzzer;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_lvl;      // level
    int         m_buzz;     // buzzer cycles remaining
    int         m_cool;     // ignored-input cycles remaining
    int         m_run;      // length of the current matching colour run (0 = none)
    int         m_idle;     // consecutive colourless idle cycles
    logic [2:0] m_col;      // colour of the current run
    bit         m_pend;     // command accepted, effect applies on next edge

    fsm_unit #(
        .DEB_CYCLES      (DEB),
        .MAX_LEVEL       (MAXL),
        .STEP            (STEP),
        .DECAY_CYCLES    (DECAY),
        .BUZZ_CYCLES     (BUZZ),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .color  (color),
        .data   (data),
        .buzzer (buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic bit is_valid(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    task automatic model_reset();
        m_lvl  = 0;
        m_buzz = 0;
        m_cool = 0;
        m_run  = 0;
        m_idle = 0;
        m_col  = 3'b000;
        m_pend = 1'b0;
    endtask

    // One rising edge of the reference behaviour, given the sampled colour.
    task automatic model_edge(input logic [2:0] c);
        if (m_buzz > 0) m_buzz--;
        if (m_pend) begin
            if (m_col == 3'b001) m_lvl = (m_lvl + STEP > MAXL) ? MAXL : m_lvl + STEP;
            else if (m_col == 3'b100) m_lvl = 0;
            m_buzz = BUZZ;
            m_cool = COOL;
            m_pend = 1'b0;
            m_run  = 0;
            m_idle = 0;
        end else if (m_cool > 0) begin
            m_cool--;
            m_idle = 0;
        end else if (m_run > 0) begin
            m_idle = 0;
            if (c == m_col) begin
                m_run++;
                if (m_run >= DEB) m_pend = 1'b1;
            end else begin
                m_run = 0;
            end
        end else if (is_valid(c)) begin
            m_col  = c;
            m_run  = 1;
            m_idle = 0;
            if (DEB == 1) m_pend = 1'b1;
        end else begin
            m_idle++;
            if (m_idle == DECAY) begin
                m_idle = 0;
                if (m_lvl > 0) m_lvl--;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("data", {4'b0000, data}, 8'(m_lvl));
        check("buzzer", {7'b0, buzzer}, 8'(m_buzz > 0));
    endtask

    // Drive a colour, take one edge, advance the model, compare away from the edge.
    task automatic tick(input logic [2:0] c);
        color = c;
        @(posedge clk);
        model_edge(c);
        #1;
        check_model();
    endtask

    task automatic ticks(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) tick(c);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #2;
        check({tag, "_data"}, {4'b0000, data}, 8'd0);
        check({tag, "_buzzer"}, {7'b0, buzzer}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        reset = 1'b1;
    endtask

    logic [2:0] tbl [6];

    initial begin
        tbl[0] = 3'b000; tbl[1] = 3'b001; tbl[2] = 3'b010;
        tbl[3] = 3'b100; tbl[4] = 3'b011; tbl[5] = 3'b111;
        model_reset();

        // Reset held low for three cycles
        #1;
        check("rst_data", {4'b0000, data}, 8'd0);
        check("rst_buzzer", {7'b0, buzzer}, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst3_data", {4'b0000, data}, 8'd0);
        reset = 1'b1;

        // No colour: level must not decay below zero
        ticks(3'b000, 30);
        check("floor_data", {4'b0000, data}, 8'd0);

        // CLEAR for one edge, then FEED held: CLEAR is never accepted
        tick(3'b100);
        ticks(3'b001, 4);
        check("feed1_data", {4'b0000, data}, 8'd2);
        check("feed1_buzzer", {7'b0, buzzer}, 8'd1);
        ticks(3'b001, 53);
        check("feed2_data", {4'b0000, data}, 8'd4);
        check("feed2_buzzer", {7'b0, buzzer}, 8'd1);
        ticks(3'b001, 53);
        check("sat_data", {4'b0000, data}, 8'd4);

        // Decay 4 -> 0 after the cooldown expires
        ticks(3'b000, 60);
        check("decay1_data", {4'b0000, data}, 8'd3);
        check("decay1_buzzer", {7'b0, buzzer}, 8'd0);
        ticks(3'b000, 40);
        check("decay_end", {4'b0000, data}, 8'd0);
        ticks(3'b000, 20);

        // One-edge CALL glitch has no effect
        tick(3'b010);
        ticks(3'b000, 5);
        check("glitch_data", {4'b0000, data}, 8'd0);
        check("glitch_buzzer", {7'b0, buzzer}, 8'd0);

        // Build level back to 4, let cooldown expire, then CLEAR
        ticks(3'b001, 60);
        ticks(3'b000, 50);
        check("prefill_data", {4'b0000, data}, 8'd4);
        ticks(3'b100, 2);
        tick(3'b001);
        check("clear_data", {4'b0000, data}, 8'd0);
        check("clear_buzzer", {7'b0, buzzer}, 8'd1);
        // Colour changes during cooldown are ignored
        ticks(3'b001, 20);
        ticks(3'b010, 10);
        ticks(3'b000, 30);
        check("cool_ignore", {4'b0000, data}, 8'd0);

        // Reset mid-buzz at level 2
        ticks(3'b001, 3);
        ticks(3'b000, 3);
        check("midbuzz_data", {4'b0000, data}, 8'd2);
        check("midbuzz_buzzer", {7'b0, buzzer}, 8'd1);
        async_reset("midbuzz_rst");

        // Randomized colour bursts
        for (int b = 0; b < 400; b++) begin
            logic [2:0] c;
            int         len;
            c   = tbl[$urandom_range(0, 5)];
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 4);
            ticks(c, len);
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
